// File: rtl/venom_fire_scheduler.sv
// Purpose: turns two players' fire-key presses into one-shot projectile spawns, with a per-player magazine, a frame-timed reload and a cap on live projectiles.
// Latency: a key first held in cycle N makes the player PENDING in N+1, and spawn_valid rises at N+2 at the earliest. Ammo and the live count update the cycle after the handshake.
// Backpressure: spawn_valid and spawn_player stay stable until spawn_ready. Requests wait in PENDING while the live cap is reached, and presses made outside READY are dropped.
module venom_fire_scheduler #(
  parameter int MAX_SHOTS     = 3,
  parameter int RELOAD_FRAMES = 120,
  parameter int MAX_ACTIVE    = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [15:0] keycode,
  input  logic [7:0]  fireKey0,
  input  logic [7:0]  fireKey1,
  input  logic        frame_tick,
  input  logic        spawn_ready,
  input  logic [1:0]  retire,
  output logic        spawn_valid,
  output logic        spawn_player,
  output logic [1:0]  ammo0,
  output logic [1:0]  ammo1,
  output logic [1:0]  reloading,
  output logic [2:0]  active_count
);

  localparam logic [2:0] SHOTS_C   = 3'(MAX_SHOTS);
  localparam logic [2:0] MAX_ACT_C = 3'(MAX_ACTIVE);
  localparam logic [7:0] RLD_C     = 8'(RELOAD_FRAMES);

  typedef enum logic [1:0] {P_READY, P_PENDING, P_FIRING, P_RELOAD} pstate_t;
  typedef enum logic {A_IDLE, A_OFFER} astate_t;

  logic [1:0] held, held_q, held_d, press;
  pstate_t    pst_q [2];
  pstate_t    pst_d [2];
  logic [1:0] used_q [2];
  logic [1:0] used_d [2];
  logic [7:0] rcnt_q [2];
  logic [7:0] rcnt_d [2];
  logic [1:0] rfresh_q, rfresh_d;
  astate_t    arb_q, arb_d;
  logic       grant_q, grant_d;
  logic       ptr_q, ptr_d;
  logic [2:0] act_q, act_d;

  logic [1:0] pending, grant_evt, hs_evt;
  logic       offer_go, grant_sel, hs;
  logic [3:0] cnt_sum, cnt_pop, cnt_diff;

  // Key decode and press-edge detection; player 0 owns a key shared by both players
  always_comb begin
    held[0] = (fireKey0 == keycode[15:8]) || (fireKey0 == keycode[7:0]);
    held[1] = ((fireKey1 == keycode[15:8]) || (fireKey1 == keycode[7:0])) &&
              (fireKey1 != fireKey0);
    held_d  = held;
    press   = held & ~held_q;
  end

  // Round-robin arbiter: picks a pending player while under the live cap, then holds the offer until the handshake
  always_comb begin
    pending[0] = (pst_q[0] == P_PENDING);
    pending[1] = (pst_q[1] == P_PENDING);
    offer_go   = (arb_q == A_IDLE) && (|pending) && (act_q < MAX_ACT_C);
    grant_sel  = pending[ptr_q] ? ptr_q : ~ptr_q;
    hs         = (arb_q == A_OFFER) && spawn_ready;
    arb_d      = arb_q;
    grant_d    = grant_q;
    ptr_d      = ptr_q;
    grant_evt  = 2'b00;
    hs_evt     = 2'b00;
    if (offer_go) begin
      arb_d     = A_OFFER;
      grant_d   = grant_sel;
      grant_evt = grant_sel ? 2'b10 : 2'b01;
    end
    if (hs) begin
      arb_d  = A_IDLE;
      ptr_d  = ~grant_q;
      hs_evt = grant_q ? 2'b10 : 2'b01;
    end
  end

  // Per-player shot FSM: magazine use, and a reload that ignores the frame tick in its entry cycle
  always_comb begin
    rfresh_d = rfresh_q;
    for (int p = 0; p < 2; p++) begin
      pst_d[p]  = pst_q[p];
      used_d[p] = used_q[p];
      rcnt_d[p] = rcnt_q[p];
      case (pst_q[p])
        P_READY: begin
          if (press[p]) pst_d[p] = P_PENDING;
        end
        P_PENDING: begin
          if (grant_evt[p]) pst_d[p] = P_FIRING;
        end
        P_FIRING: begin
          if (hs_evt[p]) begin
            used_d[p] = used_q[p] + 2'd1;
            if (({1'b0, used_q[p]} + 3'd1) >= SHOTS_C) begin
              pst_d[p]    = P_RELOAD;
              rcnt_d[p]   = RLD_C;
              rfresh_d[p] = 1'b1;
            end else begin
              pst_d[p] = P_READY;
            end
          end
        end
        default: begin
          rfresh_d[p] = 1'b0;
          if (!rfresh_q[p] && frame_tick) begin
            if (rcnt_q[p] <= 8'd1) begin
              pst_d[p]  = P_READY;
              used_d[p] = 2'd0;
              rcnt_d[p] = 8'd0;
            end else begin
              rcnt_d[p] = rcnt_q[p] - 8'd1;
            end
          end
        end
      endcase
    end
  end

  // Live projectile count: a spawn and a retire in the same cycle cancel, and the count is clamped to 0..MAX_ACTIVE
  always_comb begin
    cnt_pop  = {3'b000, retire[0]} + {3'b000, retire[1]};
    cnt_sum  = {1'b0, act_q} + {3'b000, hs};
    cnt_diff = cnt_sum - cnt_pop;
    if (cnt_sum < cnt_pop) begin
      act_d = 3'd0;
    end else if (cnt_diff > {1'b0, MAX_ACT_C}) begin
      act_d = MAX_ACT_C;
    end else begin
      act_d = cnt_diff[2:0];
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge Clk) begin
    if (Reset) begin
      held_q   <= 2'b00;
      rfresh_q <= 2'b00;
      arb_q    <= A_IDLE;
      grant_q  <= 1'b0;
      ptr_q    <= 1'b0;
      act_q    <= 3'd0;
      for (int p = 0; p < 2; p++) begin
        pst_q[p]  <= P_READY;
        used_q[p] <= 2'd0;
        rcnt_q[p] <= 8'd0;
      end
    end else begin
      held_q   <= held_d;
      rfresh_q <= rfresh_d;
      arb_q    <= arb_d;
      grant_q  <= grant_d;
      ptr_q    <= ptr_d;
      act_q    <= act_d;
      for (int p = 0; p < 2; p++) begin
        pst_q[p]  <= pst_d[p];
        used_q[p] <= used_d[p];
        rcnt_q[p] <= rcnt_d[p];
      end
    end
  end

  assign spawn_valid  = (arb_q == A_OFFER);
  assign spawn_player = grant_q;
  assign ammo0        = (pst_q[0] == P_RELOAD) ? 2'd3 : used_q[0];
  assign ammo1        = (pst_q[1] == P_RELOAD) ? 2'd3 : used_q[1];
  assign reloading    = {pst_q[1] == P_RELOAD, pst_q[0] == P_RELOAD};
  assign active_count = act_q;

endmodule

// File: tb/tb_venom_fire_scheduler.sv
// Directed bench for venom_fire_scheduler, built with RELOAD_FRAMES=4 and MAX_ACTIVE=2.
// Inputs change 1 time unit after the rising edge, and outputs are read at that same point.
// Each task drives one scenario and checks the outputs it produces against hand-computed values.
module tb_venom_fire_scheduler;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [15:0] keycode;
  logic [7:0]  fireKey0, fireKey1;
  logic        frame_tick, spawn_ready;
  logic [1:0]  retire;
  logic        spawn_valid, spawn_player;
  logic [1:0]  ammo0, ammo1, reloading;
  logic [2:0]  active_count;

  int total = 0;
  int bad   = 0;

  venom_fire_scheduler #(.MAX_SHOTS(3), .RELOAD_FRAMES(4), .MAX_ACTIVE(2)) dut (
    .Clk(Clk), .Reset(Reset), .keycode(keycode), .fireKey0(fireKey0), .fireKey1(fireKey1),
    .frame_tick(frame_tick), .spawn_ready(spawn_ready), .retire(retire),
    .spawn_valid(spawn_valid), .spawn_player(spawn_player), .ammo0(ammo0), .ammo1(ammo1),
    .reloading(reloading), .active_count(active_count)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1; keycode = 16'h0000; frame_tick = 1'b0; retire = 2'b00; spawn_ready = 1'b1;
    fireKey0 = 8'h2C; fireKey1 = 8'h34;
    tick(); tick();
    Reset = 1'b0;
  endtask

  // press kc for one cycle with spawn_ready already set; report what the bus shows two cycles later
  task automatic fire_one(input logic [15:0] kc, output logic seen, output logic who);
    keycode = kc;
    tick();
    keycode = 16'h0000;
    tick();
    seen = spawn_valid;
    who  = spawn_player;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (spawn_valid !== 1'b0 || spawn_player !== 1'b0) begin bad++; $display("FAIL reset_spawn got=%b%b exp=00", spawn_valid, spawn_player); end
    total++; if (ammo0 !== 2'd0 || ammo1 !== 2'd0) begin bad++; $display("FAIL reset_ammo got=%0d/%0d exp=0/0", ammo0, ammo1); end
    total++; if (reloading !== 2'b00 || active_count !== 3'd0) begin bad++; $display("FAIL reset_misc got=%b/%0d exp=00/0", reloading, active_count); end
  endtask

  task automatic test_single_shot();
    do_reset();
    keycode = 16'h002C;
    tick();
    keycode = 16'h0000;
    total++; if (spawn_valid !== 1'b0) begin bad++; $display("FAIL single_n1 got=%b exp=0", spawn_valid); end
    tick();
    total++; if (spawn_valid !== 1'b1 || spawn_player !== 1'b0) begin bad++; $display("FAIL single_n2 got=%b/%b exp=1/0", spawn_valid, spawn_player); end
    tick();
    total++; if (spawn_valid !== 1'b0 || ammo0 !== 2'd1 || active_count !== 3'd1) begin bad++; $display("FAIL single_n3 got=%b/%0d/%0d exp=0/1/1", spawn_valid, ammo0, active_count); end
  endtask

  task automatic test_held_key();
    int n;
    do_reset();
    n = 0;
    keycode = 16'h2C00;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (spawn_valid === 1'b1) n++;
    end
    total++; if (n !== 1 || ammo0 !== 2'd1) begin bad++; $display("FAIL held_once got=%0d/%0d exp=1/1", n, ammo0); end
    keycode = 16'h0000;
    tick();
    keycode = 16'h2C00;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      keycode = 16'h0000;
      if (spawn_valid === 1'b1) n++;
    end
    total++; if (n !== 1 || ammo0 !== 2'd2 || active_count !== 3'd2) begin bad++; $display("FAIL held_repress got=%0d/%0d/%0d exp=1/2/2", n, ammo0, active_count); end
    retire = 2'b01;
    tick(); tick();
    retire = 2'b00;
    total++; if (active_count !== 3'd0) begin bad++; $display("FAIL held_retire got=%0d exp=0", active_count); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    for (int r = 0; r < 2; r++) begin
      keycode = 16'h2C34;
      tick();
      keycode = 16'h0000;
      tick();
      total++; if (spawn_valid !== 1'b1 || spawn_player !== 1'b0) begin bad++; $display("FAIL simul_first round=%0d got=%b/%b exp=1/0", r, spawn_valid, spawn_player); end
      tick();
      total++; if (spawn_valid !== 1'b0 || ammo0 !== 2'(r + 1)) begin bad++; $display("FAIL simul_gap round=%0d got=%b/%0d exp=0/%0d", r, spawn_valid, ammo0, r + 1); end
      tick();
      total++; if (spawn_valid !== 1'b1 || spawn_player !== 1'b1) begin bad++; $display("FAIL simul_second round=%0d got=%b/%b exp=1/1", r, spawn_valid, spawn_player); end
      tick();
      total++; if (ammo1 !== 2'(r + 1) || active_count !== 3'd2) begin bad++; $display("FAIL simul_after round=%0d got=%0d/%0d exp=%0d/2", r, ammo1, active_count, r + 1); end
      retire = 2'b11;
      tick();
      retire = 2'b00;
      total++; if (active_count !== 3'd0) begin bad++; $display("FAIL simul_retire round=%0d got=%0d exp=0", r, active_count); end
    end
  endtask

  task automatic test_same_key();
    logic seen, who;
    int n;
    do_reset();
    fireKey1 = 8'h2C;
    fire_one(16'h002C, seen, who);
    total++; if (seen !== 1'b1 || who !== 1'b0) begin bad++; $display("FAIL samekey_owner got=%b/%b exp=1/0", seen, who); end
    n = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (spawn_valid === 1'b1) n++;
    end
    total++; if (n !== 0 || ammo1 !== 2'd0) begin bad++; $display("FAIL samekey_p1 got=%0d/%0d exp=0/0", n, ammo1); end
    fireKey1 = 8'h34;
  endtask

  task automatic test_reload();
    logic seen, who;
    int n;
    do_reset();
    for (int s = 0; s < 3; s++) begin
      fire_one(16'h0034, seen, who);
      total++; if (seen !== 1'b1 || who !== 1'b1) begin bad++; $display("FAIL reload_shot%0d got=%b/%b exp=1/1", s, seen, who); end
      if (s < 2) begin
        retire = 2'b10;
        tick();
        retire = 2'b00;
      end
    end
    total++; if (ammo1 !== 2'd3 || reloading !== 2'b10) begin bad++; $display("FAIL reload_entry got=%0d/%b exp=3/10", ammo1, reloading); end
    frame_tick = 1'b1;
    retire = 2'b10;
    tick();
    frame_tick = 1'b0;
    retire = 2'b00;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      keycode = (i % 4 < 2) ? 16'h0034 : 16'h0000;
      tick();
      if (spawn_valid === 1'b1) n++;
    end
    keycode = 16'h0000;
    total++; if (n !== 0 || ammo1 !== 2'd3) begin bad++; $display("FAIL reload_presses got=%0d/%0d exp=0/3", n, ammo1); end
    for (int t = 0; t < 4; t++) begin
      frame_tick = 1'b1;
      tick();
      frame_tick = 1'b0;
      if (t < 3) begin
        total++; if (ammo1 !== 2'd3 || reloading !== 2'b10) begin bad++; $display("FAIL reload_tick%0d got=%0d/%b exp=3/10", t, ammo1, reloading); end
      end else begin
        total++; if (ammo1 !== 2'd0 || reloading !== 2'b00) begin bad++; $display("FAIL reload_done got=%0d/%b exp=0/00", ammo1, reloading); end
      end
      tick();
    end
    fire_one(16'h0034, seen, who);
    total++; if (seen !== 1'b1 || ammo1 !== 2'd1) begin bad++; $display("FAIL reload_refire got=%b/%0d exp=1/1", seen, ammo1); end
  endtask

  task automatic test_backpressure_cap();
    int n;
    do_reset();
    spawn_ready = 1'b0;
    keycode = 16'h002C;
    tick();
    keycode = 16'h0034;
    tick();
    keycode = 16'h0000;
    total++; if (spawn_valid !== 1'b1 || spawn_player !== 1'b0) begin bad++; $display("FAIL bp_offer got=%b/%b exp=1/0", spawn_valid, spawn_player); end
    n = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (spawn_valid !== 1'b1 || spawn_player !== 1'b0) n++;
    end
    total++; if (n !== 0) begin bad++; $display("FAIL bp_hold unstable_cycles=%0d exp=0", n); end
    spawn_ready = 1'b1;
    tick();
    total++; if (spawn_valid !== 1'b0 || ammo0 !== 2'd1 || active_count !== 3'd1) begin bad++; $display("FAIL bp_release got=%b/%0d/%0d exp=0/1/1", spawn_valid, ammo0, active_count); end
    tick();
    total++; if (spawn_valid !== 1'b1 || spawn_player !== 1'b1) begin bad++; $display("FAIL bp_p1 got=%b/%b exp=1/1", spawn_valid, spawn_player); end
    tick();
    total++; if (active_count !== 3'd2 || ammo1 !== 2'd1) begin bad++; $display("FAIL cap_full got=%0d/%0d exp=2/1", active_count, ammo1); end
    keycode = 16'h002C;
    tick();
    keycode = 16'h0000;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (spawn_valid === 1'b1) n++;
    end
    total++; if (n !== 0 || active_count !== 3'd2) begin bad++; $display("FAIL cap_block got=%0d/%0d exp=0/2", n, active_count); end
    retire = 2'b01;
    tick();
    retire = 2'b00;
    total++; if (active_count !== 3'd1 || spawn_valid !== 1'b0) begin bad++; $display("FAIL cap_drop got=%0d/%b exp=1/0", active_count, spawn_valid); end
    tick();
    total++; if (spawn_valid !== 1'b1 || spawn_player !== 1'b0) begin bad++; $display("FAIL cap_resume got=%b/%b exp=1/0", spawn_valid, spawn_player); end
    tick();
    total++; if (active_count !== 3'd2 || ammo0 !== 2'd2) begin bad++; $display("FAIL cap_refill got=%0d/%0d exp=2/2", active_count, ammo0); end
    retire = 2'b01;
    tick();
    retire = 2'b00;
    keycode = 16'h0034;
    tick();
    keycode = 16'h0000;
    tick();
    total++; if (spawn_valid !== 1'b1 || active_count !== 3'd1) begin bad++; $display("FAIL net_offer got=%b/%0d exp=1/1", spawn_valid, active_count); end
    retire = 2'b10;
    tick();
    retire = 2'b00;
    total++; if (active_count !== 3'd1 || ammo1 !== 2'd2) begin bad++; $display("FAIL net_out got=%0d/%0d exp=1/2", active_count, ammo1); end
  endtask

  task automatic test_reset_mid_offer();
    logic seen, who;
    do_reset();
    for (int s = 0; s < 3; s++) begin
      fire_one(16'h002C, seen, who);
      retire = 2'b01;
      tick();
      retire = 2'b00;
    end
    spawn_ready = 1'b0;
    keycode = 16'h0034;
    tick();
    keycode = 16'h0000;
    tick();
    total++; if (spawn_valid !== 1'b1 || spawn_player !== 1'b1 || reloading !== 2'b01) begin bad++; $display("FAIL rst_pre got=%b/%b/%b exp=1/1/01", spawn_valid, spawn_player, reloading); end
    Reset = 1'b1;
    spawn_ready = 1'b1;
    tick();
    Reset = 1'b0;
    total++; if (spawn_valid !== 1'b0 || spawn_player !== 1'b0 || reloading !== 2'b00) begin bad++; $display("FAIL rst_outs got=%b/%b/%b exp=0/0/00", spawn_valid, spawn_player, reloading); end
    total++; if (ammo0 !== 2'd0 || ammo1 !== 2'd0 || active_count !== 3'd0) begin bad++; $display("FAIL rst_counts got=%0d/%0d/%0d exp=0/0/0", ammo0, ammo1, active_count); end
    tick();
    total++; if (spawn_valid !== 1'b0 || ammo1 !== 2'd0 || active_count !== 3'd0) begin bad++; $display("FAIL rst_after got=%b/%0d/%0d exp=0/0/0", spawn_valid, ammo1, active_count); end
  endtask

  initial begin
    test_reset();
    test_single_shot();
    test_held_key();
    test_simultaneous();
    test_same_key();
    test_reload();
    test_backpressure_cap();
    test_reset_mid_offer();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
